// File: rtl/can_error_pkg.sv
// Shared definitions for the CAN error-frame stages (error flag, error delimiter).
// State encoding and frame-length constants live here so both stages agree on them.
package can_error_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    WAIT_RECESSIVE = 2'd1,
    DELIMITER      = 2'd2,
    COMPLETE       = 2'd3
  } delim_state_t;

  localparam int DELIM_LEN   = 8;
  localparam int DOM_SEQ_LEN = 8;

  // Sized "last value" forms so the counter compares need no width casts.
  localparam logic [3:0] DELIM_LAST   = 4'(DELIM_LEN - 1);
  localparam logic [2:0] DOM_SEQ_LAST = 3'(DOM_SEQ_LEN - 1);

endpackage

// File: rtl/error_delimiter.sv
// CAN error delimiter: after an error flag, waits for the bus to go recessive
// and then counts eight recessive bits.
module error_delimiter
  import can_error_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_point,
  input  logic       error_flag_complete,
  input  logic       rx_bit,
  output logic       delimiter_bit,
  output logic [3:0] bit_counter,
  output logic       busy,
  output logic       dominant_seq_8,
  output logic       delimiter_form_error,
  output logic       delimiter_complete
);

  delim_state_t state, state_next;
  logic [3:0]   bit_counter_next;
  logic [2:0]   dom_count, dom_count_next;
  logic         dominant_seq_8_next;
  logic         form_error_next;
  logic         complete_next;

  // The delimiter is always transmitted recessive; this stage only listens.
  assign delimiter_bit = 1'b1;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_next          = state;
    bit_counter_next    = bit_counter;
    dom_count_next      = dom_count;
    dominant_seq_8_next = 1'b0;
    form_error_next     = 1'b0;
    complete_next       = 1'b0;

    unique case (state)
      IDLE: begin
        // A sample_point coinciding with the start strobe is deliberately dropped.
        if (error_flag_complete) begin
          state_next       = WAIT_RECESSIVE;
          bit_counter_next = 4'd0;
          dom_count_next   = 3'd0;
        end
      end

      WAIT_RECESSIVE: begin
        if (sample_point) begin
          if (rx_bit) begin
            bit_counter_next = 4'd1;
            state_next       = DELIMITER;
          end else begin
            dom_count_next      = dom_count + 3'd1;
            dominant_seq_8_next = (dom_count == DOM_SEQ_LAST);
          end
        end
      end

      DELIMITER: begin
        if (sample_point) begin
          if (rx_bit) begin
            bit_counter_next = bit_counter + 4'd1;
            if (bit_counter == DELIM_LAST) begin
              state_next    = COMPLETE;
              complete_next = 1'b1;
            end
          end else begin
            form_error_next  = 1'b1;
            bit_counter_next = 4'd0;
            state_next       = IDLE;
          end
        end
      end

      COMPLETE: begin
        state_next       = IDLE;
        bit_counter_next = 4'd0;
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      bit_counter          <= 4'd0;
      dom_count            <= 3'd0;
      busy                 <= 1'b0;
      dominant_seq_8       <= 1'b0;
      delimiter_form_error <= 1'b0;
      delimiter_complete   <= 1'b0;
    end else if (!enable) begin
      state                <= IDLE;
      bit_counter          <= 4'd0;
      dom_count            <= 3'd0;
      busy                 <= 1'b0;
      dominant_seq_8       <= 1'b0;
      delimiter_form_error <= 1'b0;
      delimiter_complete   <= 1'b0;
    end else begin
      state                <= state_next;
      bit_counter          <= bit_counter_next;
      dom_count            <= dom_count_next;
      busy                 <= (state_next != IDLE);
      dominant_seq_8       <= dominant_seq_8_next;
      delimiter_form_error <= form_error_next;
      delimiter_complete   <= complete_next;
    end
  end

endmodule

// File: tb/tb_error_delimiter.sv
// Self-checking bench for error_delimiter: directed scenarios followed by
// randomized traffic, all compared each cycle against a behavioural model.
module tb_error_delimiter;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       sample_point;
  logic       error_flag_complete;
  logic       rx_bit;
  logic       delimiter_bit;
  logic [3:0] bit_counter;
  logic       busy;
  logic       dominant_seq_8;
  logic       delimiter_form_error;
  logic       delimiter_complete;

  error_delimiter dut (
    .clock                (clock),
    .reset                (reset),
    .enable               (enable),
    .sample_point         (sample_point),
    .error_flag_complete  (error_flag_complete),
    .rx_bit               (rx_bit),
    .delimiter_bit        (delimiter_bit),
    .bit_counter          (bit_counter),
    .busy                 (busy),
    .dominant_seq_8       (dominant_seq_8),
    .delimiter_form_error (delimiter_form_error),
    .delimiter_complete   (delimiter_complete)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;

  // Behavioural model: an in-progress flag, the recessive run length and the
  // total dominant samples seen before the first recessive bit.
  bit m_active;
  int m_rec;
  int m_dom;
  bit m_seq, m_ferr, m_comp;

  int seq_seen, ferr_seen, comp_seen;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_active = 1'b0;
    m_rec    = 0;
    m_dom    = 0;
    m_seq    = 1'b0;
    m_ferr   = 1'b0;
    m_comp   = 1'b0;
  endtask

  task automatic model_edge(input logic efc, input logic sp, input logic rx);
    bit was_comp;
    if (!enable) begin
      model_clear();
    end else begin
      was_comp = m_comp;
      m_comp = 1'b0;
      m_seq  = 1'b0;
      m_ferr = 1'b0;
      if (was_comp) begin
        m_rec = 0;
      end else if (!m_active) begin
        if (efc) begin
          m_active = 1'b1;
          m_rec    = 0;
          m_dom    = 0;
        end
      end else if (sp) begin
        if (rx) begin
          m_rec++;
          if (m_rec == 8) begin
            m_active = 1'b0;
            m_comp   = 1'b1;
          end
        end else if (m_rec == 0) begin
          m_dom++;
          m_seq = (m_dom % 8 == 0);
        end else begin
          m_ferr   = 1'b1;
          m_rec    = 0;
          m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".delimiter_bit"}, 8'(delimiter_bit), 8'd1);
    check({tag, ".bit_counter"}, 8'(bit_counter), 8'(m_rec));
    check({tag, ".busy"}, 8'(busy), 8'(m_active || m_comp));
    check({tag, ".dominant_seq_8"}, 8'(dominant_seq_8), 8'(m_seq));
    check({tag, ".form_error"}, 8'(delimiter_form_error), 8'(m_ferr));
    check({tag, ".complete"}, 8'(delimiter_complete), 8'(m_comp));
  endtask

  task automatic step(input string tag, input logic efc, input logic sp, input logic rx);
    error_flag_complete = efc;
    sample_point        = sp;
    rx_bit              = rx;
    @(posedge clock);
    model_edge(efc, sp, rx);
    #1;
    if (dominant_seq_8)       seq_seen++;
    if (delimiter_form_error) ferr_seen++;
    if (delimiter_complete)   comp_seen++;
    compare_all(tag);
  endtask

  task automatic start(input string tag);
    step(tag, 1'b1, 1'b0, 1'b0);
  endtask

  // One sampled bit followed by a gap cycle without a sample_point.
  task automatic bit_sample(input string tag, input logic rx);
    step(tag, 1'b0, 1'b1, rx);
    step(tag, 1'b0, 1'b0, rx);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear_seen();
    seq_seen  = 0;
    ferr_seen = 0;
    comp_seen = 0;
  endtask

  initial begin
    reset               = 1'b1;
    enable              = 1'b1;
    sample_point        = 1'b0;
    error_flag_complete = 1'b0;
    rx_bit              = 1'b1;
    model_clear();
    clear_seen();
    #3;
    compare_all("reset");
    @(negedge clock);
    reset = 1'b0;
    idle("post_reset", 2);

    // Eight recessive samples straight away.
    clear_seen();
    start("r8");
    for (int i = 0; i < 8; i++) bit_sample("r8", 1'b1);
    idle("r8", 2);
    check("r8.complete_count", 8'(comp_seen), 8'd1);

    // Three dominant then eight recessive.
    clear_seen();
    start("d3r8");
    for (int i = 0; i < 3; i++) bit_sample("d3r8", 1'b0);
    for (int i = 0; i < 8; i++) bit_sample("d3r8", 1'b1);
    idle("d3r8", 2);
    check("d3r8.seq_count", 8'(seq_seen), 8'd0);
    check("d3r8.complete_count", 8'(comp_seen), 8'd1);

    // Seventeen dominant then eight recessive: two sequence pulses.
    clear_seen();
    start("d17r8");
    for (int i = 0; i < 17; i++) step("d17r8", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) bit_sample("d17r8", 1'b1);
    idle("d17r8", 2);
    check("d17r8.seq_count", 8'(seq_seen), 8'd2);
    check("d17r8.complete_count", 8'(comp_seen), 8'd1);

    // Form error after four recessive bits.
    clear_seen();
    start("ferr");
    for (int i = 0; i < 4; i++) bit_sample("ferr", 1'b1);
    bit_sample("ferr", 1'b0);
    idle("ferr", 3);
    check("ferr.ferr_count", 8'(ferr_seen), 8'd1);
    check("ferr.complete_count", 8'(comp_seen), 8'd0);

    // Start held two cycles, first one with a coincident recessive sample.
    clear_seen();
    step("start2", 1'b1, 1'b1, 1'b1);
    step("start2", 1'b1, 1'b0, 1'b1);
    check("start2.bit_counter", 8'(bit_counter), 8'd0);
    for (int i = 0; i < 8; i++) bit_sample("start2", 1'b1);
    idle("start2", 2);
    check("start2.complete_count", 8'(comp_seen), 8'd1);

    // Asynchronous reset after five recessive bits.
    clear_seen();
    start("areset");
    for (int i = 0; i < 5; i++) bit_sample("areset", 1'b1);
    #2 reset = 1'b1;
    model_clear();
    #1 compare_all("areset.now");
    #2 reset = 1'b0;
    idle("areset", 12);
    check("areset.pulses", 8'(ferr_seen + comp_seen), 8'd0);

    // Synchronous abort via enable after five recessive bits.
    clear_seen();
    start("enable");
    for (int i = 0; i < 5; i++) bit_sample("enable", 1'b1);
    enable = 1'b0;
    step("enable.low", 1'b0, 1'b1, 1'b1);
    enable = 1'b1;
    idle("enable", 12);
    check("enable.pulses", 8'(ferr_seen + comp_seen), 8'd0);

    // Randomized traffic, alternating between mostly-recessive and mostly-dominant buses.
    for (int i = 0; i < 4000; i++) begin
      int rec_pct;
      rec_pct = ((i / 400) % 2 == 0) ? 85 : 10;
      enable  = ($urandom_range(0, 199) != 0);
      step("rand",
           logic'($urandom_range(0, 99) < 6),
           logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 99) < rec_pct));
    end
    enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/error_delimiter.md
ERROR_DELIMITER -- requirements
Module: error_delimiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-004 enable  input  1  synchronous block enable; low forces reset state on next edge.
REQ-005 sample_point  input  1  one-cycle strobe marking the CAN bit sample instant.
REQ-006 error_flag_complete  input  1  start strobe from the upstream error-flag stage; may stay high up to 2 cycles.
REQ-007 rx_bit  input  1  bus level at sample_point (0 = dominant, 1 = recessive).
REQ-008 delimiter_bit  output  1  transmitted bit; constant 1 (recessive) in every state.
REQ-009 bit_counter  output  4  count of recessive delimiter bits received so far (0..8).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 dominant_seq_8  output  1  one-cycle pulse per 8 consecutive dominant bits seen while waiting for recessive.
REQ-012 delimiter_form_error  output  1  one-cycle pulse when a dominant bit breaks the delimiter.
REQ-013 delimiter_complete  output  1  one-cycle pulse after 8 consecutive recessive bits.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_RECESSIVE, DELIMITER, COMPLETE; all outputs registered.
REQ-015 IDLE: error_flag_complete=1 SHALL move to WAIT_RECESSIVE next edge, clearing bit_counter and the 3-bit dominant counter; a coincident sample_point is ignored.
REQ-016 error_flag_complete while not in IDLE SHALL be ignored.
REQ-017 WAIT_RECESSIVE, sample_point with rx_bit=0: dominant counter SHALL increment modulo 8; when it wraps 7->0, dominant_seq_8 pulses that edge.
REQ-018 WAIT_RECESSIVE SHALL have no timeout; a stuck-dominant bus produces a dominant_seq_8 pulse every 8th dominant sample indefinitely.
REQ-019 WAIT_RECESSIVE, sample_point with rx_bit=1: that bit SHALL count as delimiter bit 1; bit_counter=1, state DELIMITER.
REQ-020 DELIMITER, sample_point with rx_bit=1: bit_counter SHALL increment; on the sample that makes it 8, state COMPLETE.
REQ-021 DELIMITER, sample_point with rx_bit=0: delimiter_form_error SHALL pulse, bit_counter clears, state IDLE.
REQ-022 COMPLETE: delimiter_complete SHALL be high exactly one cycle, bit_counter holds 8, next state IDLE (bit_counter clears to 0 on entering IDLE).
REQ-023 Cycles without sample_point SHALL leave counters and state unchanged (except COMPLETE->IDLE).
REQ-024 Pulse outputs SHALL be low in every cycle not named above.

Reset
REQ-025 On reset (async) or enable=0 (sync): state IDLE, delimiter_bit=1, bit_counter=0, dominant counter=0, busy=0, all pulse outputs 0.
REQ-026 Reset or enable=0 mid-operation SHALL abort silently with no delimiter_complete or delimiter_form_error pulse.

Structure
REQ-027 The state enum and constants DELIM_LEN=8 and DOM_SEQ_LEN=8 SHALL live in shared package can_error_pkg, also used by the error-flag stage.
REQ-028 The block SHALL be a single module without sub-modules; counters are inline.

Verification
REQ-029 Start pulse, then 8 recessive samples -> bit_counter 1..8, delimiter_complete one cycle after 8th sample, busy low after.
REQ-030 Start, 3 dominant then 8 recessive -> no dominant_seq_8, delimiter_complete after the 11th sample.
REQ-031 Start, 17 dominant then 8 recessive -> dominant_seq_8 pulses at dominant samples 8 and 16 only, then delimiter_complete.
REQ-032 Start, 4 recessive, 1 dominant -> delimiter_form_error one cycle, bit_counter 0, state IDLE, no delimiter_complete.
REQ-033 Start held high 2 cycles coincident with sample_point -> single entry to WAIT_RECESSIVE, coincident sample ignored.
REQ-034 reset asserted after 5 recessive samples -> outputs at reset values immediately, no pulses; same for enable=0 at next edge.
